// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan reader.
package seg7_pkg;

    typedef logic [4:0] code_t;

    localparam code_t CODE_BLANK = 5'd16;
    localparam code_t CODE_DASH  = 5'd17;
    localparam code_t CODE_R     = 5'd18;
    localparam code_t CODE_BAD   = 5'd31;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_A     = 7'h77;
    localparam logic [6:0] PAT_B     = 7'h7C;
    localparam logic [6:0] PAT_C     = 7'h39;
    localparam logic [6:0] PAT_D     = 7'h5E;
    localparam logic [6:0] PAT_E     = 7'h79;
    localparam logic [6:0] PAT_F     = 7'h71;
    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_DASH  = 7'h40;
    localparam logic [6:0] PAT_R     = 7'h50;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to character code, with unknown-pattern flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output code_t      code,
    output logic       bad
);

    // Table lookup; anything not in the character set is reported as bad
    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (pat)
            PAT_0:     code = 5'd0;
            PAT_1:     code = 5'd1;
            PAT_2:     code = 5'd2;
            PAT_3:     code = 5'd3;
            PAT_4:     code = 5'd4;
            PAT_5:     code = 5'd5;
            PAT_6:     code = 5'd6;
            PAT_7:     code = 5'd7;
            PAT_8:     code = 5'd8;
            PAT_9:     code = 5'd9;
            PAT_A:     code = 5'd10;
            PAT_B:     code = 5'd11;
            PAT_C:     code = 5'd12;
            PAT_D:     code = 5'd13;
            PAT_E:     code = 5'd14;
            PAT_F:     code = 5'd15;
            PAT_BLANK: code = CODE_BLANK;
            PAT_DASH:  code = CODE_DASH;
            PAT_R:     code = CODE_R;
            default: begin
                code = CODE_BAD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reader for the multiplexed 7-segment bus: rebuilds the four displayed
// characters, flags illegal anode/segment patterns and a stalled scan.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic       MCLK,
    input  logic       MR_N,
    input  logic [7:0] SEG7,
    input  logic [3:0] ENSEG,
    input  logic       CLR_ERR,
    output code_t      DIG0,
    output code_t      DIG1,
    output code_t      DIG2,
    output code_t      DIG3,
    output logic [3:0] DP,
    output logic       FRAME_VLD,
    output logic       CHANGED,
    output logic       SEG_ERR,
    output logic       AN_ERR,
    output logic       STALE
);

    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMAX       = TW'(TIMEOUT_CYC);

    logic [7:0]    seg_r, seg_p;
    logic [3:0]    en_r, en_p;
    state_t        state;
    logic [CW-1:0] cnt;
    code_t         shadow [4];
    logic [3:0]    shadow_dp;
    logic [3:0]    seen;
    logic          frame_pend;
    logic [TW-1:0] tcnt;

    logic          onehot;
    logic          multi;
    logic          diff;
    logic [1:0]    idx;
    logic          accept;
    code_t         dec_code;
    logic          dec_bad;

    seg7_pattern_decode u_dec (
        .pat  (seg_r[6:0]),
        .code (dec_code),
        .bad  (dec_bad)
    );

    // Input stage: register and normalise to active-high; keep previous copy for change detect
    always_ff @(posedge MCLK or negedge MR_N) begin
        if (!MR_N) begin
            seg_r <= '0;
            en_r  <= '0;
            seg_p <= '0;
            en_p  <= '0;
        end else begin
            seg_r <= SEG_ACT_LOW ? ~SEG7 : SEG7;
            en_r  <= AN_ACT_LOW ? ~ENSEG : ENSEG;
            seg_p <= seg_r;
            en_p  <= en_r;
        end
    end

    // Qualifiers for the FSM: enable shape, stability, and the accept condition
    always_comb begin
        onehot = is_onehot(en_r);
        multi  = !onehot && (en_r != 4'b0000);
        diff   = (en_r != en_p) || (seg_r != seg_p);
        idx    = onehot_idx(en_r);
        accept = (state == SETTLE) && onehot && !diff && (cnt == SETTLE_MAX);
    end

    // Scan FSM with shadow capture, seen mask and sticky error flags
    always_ff @(posedge MCLK or negedge MR_N) begin
        if (!MR_N) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow_dp  <= '0;
            seen       <= '0;
            frame_pend <= 1'b0;
            SEG_ERR    <= 1'b0;
            AN_ERR     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i] <= CODE_BLANK;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (onehot) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end
                end
                SETTLE: begin
                    if (!onehot) begin
                        state <= IDLE;
                    end else if (diff) begin
                        cnt <= CW'(1);
                    end else if (cnt == SETTLE_MAX) begin
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (diff) begin
                        if (onehot) begin
                            state <= SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Accepts are always at least two cycles apart, so clearing on the
            // frame copy cycle never collides with a new accept.
            if (frame_pend) begin
                seen <= '0;
            end else if (accept) begin
                seen[idx] <= 1'b1;
            end

            if (accept) begin
                shadow[idx]    <= dec_code;
                shadow_dp[idx] <= seg_r[7];
            end
            frame_pend <= accept && ((seen | (4'b0001 << idx)) == 4'b1111);

            SEG_ERR <= (accept && dec_bad) || (SEG_ERR && !CLR_ERR);
            AN_ERR  <= multi || (AN_ERR && !CLR_ERR);
        end
    end

    // Publish a completed frame one cycle after its last accept
    always_ff @(posedge MCLK or negedge MR_N) begin
        if (!MR_N) begin
            DIG0      <= CODE_BLANK;
            DIG1      <= CODE_BLANK;
            DIG2      <= CODE_BLANK;
            DIG3      <= CODE_BLANK;
            DP        <= '0;
            FRAME_VLD <= 1'b0;
            CHANGED   <= 1'b0;
        end else if (frame_pend) begin
            DIG0      <= shadow[0];
            DIG1      <= shadow[1];
            DIG2      <= shadow[2];
            DIG3      <= shadow[3];
            DP        <= shadow_dp;
            FRAME_VLD <= 1'b1;
            CHANGED   <= (shadow[0] != DIG0) || (shadow[1] != DIG1) ||
                         (shadow[2] != DIG2) || (shadow[3] != DIG3) ||
                         (shadow_dp != DP);
        end else begin
            FRAME_VLD <= 1'b0;
            CHANGED   <= 1'b0;
        end
    end

    // Frame timeout: saturating counter, STALE high while saturated
    always_ff @(posedge MCLK or negedge MR_N) begin
        if (!MR_N) begin
            tcnt  <= '0;
            STALE <= 1'b0;
        end else if (frame_pend) begin
            tcnt  <= '0;
            STALE <= 1'b0;
        end else if (tcnt != TMAX) begin
            tcnt  <= tcnt + TW'(1);
            STALE <= ((tcnt + TW'(1)) == TMAX);
        end else begin
            STALE <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (active-low bus, SETTLE_CYC=4).
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int unsigned TMO = 300;

    logic       MCLK = 1'b0;
    logic       MR_N = 1'b0;
    logic [7:0] SEG7 = 8'hFF;
    logic [3:0] ENSEG = 4'hF;
    logic       CLR_ERR = 1'b0;
    code_t      DIG0, DIG1, DIG2, DIG3;
    logic [3:0] DP;
    logic       FRAME_VLD, CHANGED, SEG_ERR, AN_ERR, STALE;

    typedef struct packed {
        logic [3:0][4:0] dig;
        logic [3:0]      dp;
        logic            chg;
    } frame_t;

    frame_t q[$];
    frame_t last;
    frame_t mf;
    int     n_total = 0;
    int     n_bad = 0;
    int     frames_pushed = 0;
    int     frames_seen = 0;

    seg7_scan_decoder #(
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .MCLK      (MCLK),
        .MR_N      (MR_N),
        .SEG7      (SEG7),
        .ENSEG     (ENSEG),
        .CLR_ERR   (CLR_ERR),
        .DIG0      (DIG0),
        .DIG1      (DIG1),
        .DIG2      (DIG2),
        .DIG3      (DIG3),
        .DP        (DP),
        .FRAME_VLD (FRAME_VLD),
        .CHANGED   (CHANGED),
        .SEG_ERR   (SEG_ERR),
        .AN_ERR    (AN_ERR),
        .STALE     (STALE)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0][4:0] dig, input logic [3:0] dp);
        frame_t f;
        f.dig = dig;
        f.dp  = dp;
        f.chg = (dig != last.dig) || (dp != last.dp);
        last.dig = dig;
        last.dp  = dp;
        last.chg = 1'b0;
        q.push_back(f);
        frames_pushed++;
    endtask

    // Raw active-low drive of one digit for ncyc clocks
    task automatic drive_digit(input int idx, input logic [7:0] raw, input int ncyc);
        ENSEG = ~(4'b0001 << idx);
        SEG7  = raw;
        repeat (ncyc) @(posedge MCLK);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge MCLK);
        #1;
        chk(tag, q.size(), 0);
    endtask

    // Output side of the scoreboard
    always @(negedge MCLK) begin
        if (MR_N) begin
            chk("chg_without_frame", CHANGED & ~FRAME_VLD, 0);
            if (FRAME_VLD) begin
                frames_seen++;
                chk("frame_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    mf = q.pop_front();
                    chk("dig0", DIG0, mf.dig[0]);
                    chk("dig1", DIG1, mf.dig[1]);
                    chk("dig2", DIG2, mf.dig[2]);
                    chk("dig3", DIG3, mf.dig[3]);
                    chk("dp", DP, mf.dp);
                    chk("changed", CHANGED, mf.chg);
                    chk("stale_at_frame", STALE, 0);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge MCLK);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last.dig = {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};
        last.dp  = 4'b0000;
        last.chg = 1'b0;

        // 1: reset values, then idle bus until STALE
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_dig0", DIG0, 16);
        chk("rst_dig1", DIG1, 16);
        chk("rst_dig2", DIG2, 16);
        chk("rst_dig3", DIG3, 16);
        chk("rst_dp", DP, 0);
        chk("rst_vld", FRAME_VLD, 0);
        chk("rst_flags", {CHANGED, SEG_ERR, AN_ERR, STALE}, 0);
        MR_N = 1'b1;
        repeat (TMO - 10) @(posedge MCLK);
        #1;
        chk("stale_early", STALE, 0);
        repeat (15) @(posedge MCLK);
        #1;
        chk("stale_set", STALE, 1);

        // 2: "0510" twice
        for (int p = 0; p < 2; p++) begin
            drive_digit(0, 8'hC0, 8);
            drive_digit(1, 8'hF9, 8);
            drive_digit(2, 8'h92, 8);
            push_frame({5'd0, 5'd5, 5'd1, 5'd0}, 4'b0000);
            drive_digit(3, 8'hC0, 8);
            wait_drain("drain_0510");
        end
        chk("stale_cleared", STALE, 0);

        // 3: glitching digit 0 must never be accepted
        ENSEG = 4'hE;
        for (int i = 0; i < 10; i++) begin
            SEG7 = (i % 2 == 0) ? 8'hC0 : 8'hF9;
            repeat (3) @(posedge MCLK);
            #1;
        end

        // 4: "Err " in reverse scan order; a stray digit-0 accept would frame early
        drive_digit(3, 8'h86, 8);
        drive_digit(2, 8'hAF, 8);
        drive_digit(1, 8'hAF, 8);
        push_frame({5'd14, 5'd18, 5'd18, 5'd16}, 4'b0000);
        drive_digit(0, 8'hFF, 8);
        wait_drain("drain_err");
        chk("seg_err_clean", SEG_ERR, 0);

        drive_digit(3, 8'h86, 8);
        drive_digit(2, 8'h2F, 8);
        drive_digit(1, 8'hAA, 8);
        push_frame({5'd14, 5'd18, 5'd31, 5'd16}, 4'b0100);
        drive_digit(0, 8'hFF, 8);
        wait_drain("drain_bad");
        chk("seg_err_set", SEG_ERR, 1);

        // 5: error clear and multi-hot enables
        CLR_ERR = 1'b1;
        @(posedge MCLK);
        #1;
        CLR_ERR = 1'b0;
        chk("seg_err_clr", SEG_ERR, 0);
        chk("an_err_before", AN_ERR, 0);
        ENSEG = 4'b1100;
        repeat (10) @(posedge MCLK);
        #1;
        chk("an_err_set", AN_ERR, 1);
        CLR_ERR = 1'b1;
        @(posedge MCLK);
        #1;
        CLR_ERR = 1'b0;
        chk("an_err_set_wins", AN_ERR, 1);
        ENSEG = 4'hF;
        repeat (3) @(posedge MCLK);
        #1;
        CLR_ERR = 1'b1;
        @(posedge MCLK);
        #1;
        CLR_ERR = 1'b0;
        chk("an_err_clr", AN_ERR, 0);

        // 6: reset mid-frame discards the partial frame
        drive_digit(0, 8'hC0, 8);
        drive_digit(1, 8'hC0, 8);
        MR_N = 1'b0;
        #1;
        chk("mid_rst_dig1", DIG1, 16);
        chk("mid_rst_dp", DP, 0);
        chk("mid_rst_flags", {FRAME_VLD, SEG_ERR, AN_ERR, STALE}, 0);
        last.dig = {CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};
        last.dp  = 4'b0000;
        @(posedge MCLK);
        #1;
        MR_N = 1'b1;
        drive_digit(2, 8'h99, 8);
        drive_digit(3, 8'h88, 8);
        drive_digit(0, 8'hBF, 8);
        push_frame({5'd10, 5'd4, 5'd11, 5'd17}, 4'b0000);
        drive_digit(1, 8'h83, 8);
        wait_drain("drain_after_rst");

        chk("frame_count", frames_seen, frames_pushed);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
